// File: rtl/bcd_seq_scan.sv
// N-digit cascaded BCD up/down counter with load, wrap/saturate terminal mode
// and a time-multiplexed common-anode 7-segment driver.
module bcd_seq_scan #(
  parameter int N_DIGITS = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1,
  parameter int SCAN_HZ  = 1000,
  parameter int WRAP     = 1
) (
  input  logic                  clk100M,
  input  logic                  sys_rst,
  input  logic                  en,
  input  logic                  U_D,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic [N_DIGITS-1:0]   dp_sel,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  carry,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DP,
  output logic [7:0]            AN
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic          tick;
  logic          scan_max;

  logic [4*N_DIGITS-1:0] nxt;
  logic [4*N_DIGITS-1:0] lv;
  logic                  term;
  logic                  rip;
  logic [3:0]            d;

  logic [3:0] cur;
  logic       dp_cur;
  logic [7:0] an_nxt;

  assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
  assign scan_max = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk100M) begin
    if (sys_rst)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Ripple carry/borrow through all digits in one cycle; term = all-9/all-0
  always_comb begin
    nxt = count;
    rip = 1'b1;
    d   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = count[4*i +: 4];
      if (rip) begin
        if (U_D) begin
          if (d == 4'd9) begin
            nxt[4*i +: 4] = 4'd0;
          end else begin
            nxt[4*i +: 4] = d + 4'd1;
            rip = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            nxt[4*i +: 4] = 4'd9;
          end else begin
            nxt[4*i +: 4] = d - 4'd1;
            rip = 1'b0;
          end
        end
      end
    end
    term = rip;
  end

  always_comb begin
    lv = load_val;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) lv[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk100M) begin
    if (sys_rst) begin
      count <= '0;
      carry <= 1'b0;
    end else if (load) begin
      count <= lv;
      carry <= 1'b0;
    end else if (tick && en) begin
      carry <= term;
      if (!term || WRAP != 0) count <= nxt;
    end else begin
      carry <= 1'b0;
    end
  end

  always_ff @(posedge clk100M) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_max) begin
      scan_cnt <= '0;
      if (idx == IW'(N_DIGITS - 1)) idx <= '0;
      else                          idx <= idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    cur    = '0;
    dp_cur = 1'b0;
    an_nxt = 8'hFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur       = count[4*i +: 4];
        dp_cur    = dp_sel[i];
        an_nxt[i] = 1'b0;
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk100M) begin
    if (sys_rst) begin
      {CA, CB, CC, CD, CE, CF, CG} <= 7'b1111111;
      DP <= 1'b1;
      AN <= 8'hFF;
    end else begin
      {CA, CB, CC, CD, CE, CF, CG} <= seg_of(cur);
      DP <= ~dp_cur;
      AN <= an_nxt;
    end
  end

endmodule
